// File: rtl/shift_in_reg.sv
// shift_in_reg: serial-in, parallel-out word receiver.
//
// This block sits at the far end of a 1-bit serial link. It takes an MSB-first
// bit stream and rebuilds each WIDTH-bit word. Each finished word is held on Q
// until the consumer takes it, using a VALID/ACK handshake.
//
// Ports:
//   CLK   - system clock; all state changes on the rising edge
//   RST   - asynchronous, active-high reset
//   SIN   - serial data bit, sampled when SHIFT=1
//   SHIFT - shift strobe; one bit is accepted per cycle with SHIFT=1
//   SYNC  - word alignment; drops any partial word and restarts at bit 0
//   ACK   - consumer accepts Q; clears VALID
//   Q     - last completed word; Q[WIDTH-1] is the first bit received
//   VALID - Q holds a word that has not been acknowledged yet
//   OVR   - sticky overrun flag, set when a finished word had to be dropped
//   BUSY  - a partial word is in progress (bit count is not zero)

module shift_in_reg #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SHIFT,
    input  logic             SYNC,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             OVR,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] word_in;

    // The word as it will look once the current SIN bit has been shifted in.
    // On the completing bit this goes straight to Q, so the word is not
    // delayed by an extra cycle.
    assign word_in = {sr_q[WIDTH-2:0], SIN};

    // Next-state logic.
    // SYNC has priority over SHIFT. ACK is still honoured during a SYNC
    // cycle. When a word completes in the same cycle as an ACK, the new word
    // replaces the one being acknowledged and VALID stays high, so
    // back-to-back words leave no gap.
    always_comb begin
        sr_d    = sr_q;
        count_d = count_q;
        q_d     = q_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (SYNC) begin
            sr_d    = '0;
            count_d = '0;
            ovr_d   = 1'b0;
            if (ACK) begin
                valid_d = 1'b0;
            end
        end else if (SHIFT) begin
            sr_d = word_in;
            if (count_q == LAST_BIT) begin
                count_d = '0;
                if (!valid_q || ACK) begin
                    q_d     = word_in;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                count_d = count_q + 1'b1;
                if (ACK) begin
                    valid_d = 1'b0;
                end
            end
        end else if (ACK) begin
            valid_d = 1'b0;
        end

        // BUSY is computed from the next count and registered, so it
        // matches count_q != 0 but comes straight from a flop.
        busy_d = (count_d != '0);
    end

    // State registers, asynchronously cleared by RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr_q    <= '0;
            count_q <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            count_q <= count_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign OVR   = ovr_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_shift_in_reg.sv
// tb_shift_in_reg: directed testbench for shift_in_reg with WIDTH=4.
//
// Each task drives one scenario and checks the expected values inline.
// Inputs change 1 time unit after the rising edge. Outputs are sampled at the
// same point, so nothing is read on the active edge itself.

module tb_shift_in_reg;

    logic       CLK;
    logic       RST;
    logic       SIN;
    logic       SHIFT;
    logic       SYNC;
    logic       ACK;
    logic [3:0] Q;
    logic       VALID;
    logic       OVR;
    logic       BUSY;

    int errors;
    int checks;

    shift_in_reg #(.WIDTH(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .SIN  (SIN),
        .SHIFT(SHIFT),
        .SYNC (SYNC),
        .ACK  (ACK),
        .Q    (Q),
        .VALID(VALID),
        .OVR  (OVR),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Applies one cycle of inputs, then waits until just after the next
    // rising edge so the outputs can be sampled.
    task automatic drive(input logic shift, input logic sin, input logic sync, input logic ack);
        SHIFT = shift;
        SIN   = sin;
        SYNC  = sync;
        ACK   = ack;
        @(posedge CLK);
        #1;
        SHIFT = 1'b0;
        SYNC  = 1'b0;
        ACK   = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        SHIFT = 1'b0; SIN = 1'b0; SYNC = 1'b0; ACK = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({Q, VALID, OVR, BUSY} !== 7'b0000_000) begin
            errors++;
            $display("[TB] FAIL reset_state: got Q=%b V=%b O=%b B=%b, want all zero", Q, VALID, OVR, BUSY);
        end
        RST = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_basic_word();
        logic [3:0] bits;
        bits = 4'b1011;
        for (int i = 3; i >= 1; i--) begin
            drive(1'b1, bits[i], 1'b0, 1'b0);
            checks++;
            if (BUSY !== 1'b1 || VALID !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_busy bit%0d: got B=%b V=%b, want B=1 V=0", 4 - i, BUSY, VALID);
            end
        end
        drive(1'b1, bits[0], 1'b0, 1'b0);
        checks++;
        if (Q !== 4'b1011 || VALID !== 1'b1 || BUSY !== 1'b0 || OVR !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_word: got Q=%b V=%b B=%b O=%b, want Q=1011 V=1 B=0 O=0", Q, VALID, BUSY, OVR);
        end
    endtask

    task automatic test_overrun();
        logic [3:0] bits;
        bits = 4'b0110;
        for (int i = 3; i >= 0; i--) drive(1'b1, bits[i], 1'b0, 1'b0);
        checks++;
        if (Q !== 4'b1011 || OVR !== 1'b1 || VALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_drop: got Q=%b O=%b V=%b, want Q=1011 O=1 V=1", Q, OVR, VALID);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (VALID !== 1'b0 || OVR !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_ack: got V=%b O=%b, want V=0 O=1", VALID, OVR);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (OVR !== 1'b0 || Q !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL overrun_sync_clear: got O=%b Q=%b, want O=0 Q=1011", OVR, Q);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b1100_0011;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0, (i == 4 || i == 0));
            if (i == 4) begin
                checks++;
                if (Q !== 4'b1100 || VALID !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_first: got Q=%b V=%b, want Q=1100 V=1", Q, VALID);
                end
            end else if (i < 4) begin
                checks++;
                if (VALID !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_valid_hold bit%0d: got V=%b, want V=1", 7 - i, VALID);
                end
            end
        end
        checks++;
        if (Q !== 4'b0011 || VALID !== 1'b1 || OVR !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second: got Q=%b V=%b O=%b, want Q=0011 V=1 O=0", Q, VALID, OVR);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_sync_realign();
        logic [3:0] bits;
        bits = 4'b1001;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_partial_busy: got B=%b, want B=1", BUSY);
        end
        // SHIFT is also high here, but SYNC takes priority so the bit is dropped.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (BUSY !== 1'b0 || VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sync_busy_clear: got B=%b V=%b, want B=0 V=0", BUSY, VALID);
        end
        for (int i = 3; i >= 0; i--) drive(1'b1, bits[i], 1'b0, 1'b0);
        checks++;
        if (Q !== 4'b1001 || VALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_word: got Q=%b V=%b, want Q=1001 V=1", Q, VALID);
        end
    endtask

    task automatic test_async_reset_mid_word();
        logic [3:0] bits;
        bits = 4'b0101;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (Q !== 4'b0000 || VALID !== 1'b0 || BUSY !== 1'b0 || OVR !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got Q=%b V=%b B=%b O=%b, want all zero", Q, VALID, BUSY, OVR);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 3; i >= 0; i--) drive(1'b1, bits[i], 1'b0, 1'b0);
        checks++;
        if (Q !== 4'b0101 || VALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_then_word: got Q=%b V=%b, want Q=0101 V=1", Q, VALID);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gapped_shift();
        logic [3:0] bits;
        bits = 4'b1110;
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0, 1'b0);
            if (i > 0) begin
                drive(1'b0, ~bits[i], 1'b0, 1'b0);
                drive(1'b0, bits[i], 1'b0, 1'b0);
                checks++;
                if (BUSY !== 1'b1 || VALID !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap_hold bit%0d: got B=%b V=%b, want B=1 V=0", 4 - i, BUSY, VALID);
                end
            end
        end
        checks++;
        if (Q !== 4'b1110 || VALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gap_word: got Q=%b V=%b, want Q=1110 V=1", Q, VALID);
        end
    endtask

    task automatic test_sync_with_ack();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (VALID !== 1'b0 || Q !== 4'b1110 || BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sync_ack: got V=%b Q=%b B=%b, want V=0 Q=1110 B=0", VALID, Q, BUSY);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic_word();
        test_overrun();
        test_back_to_back();
        test_sync_realign();
        test_async_reset_mid_word();
        test_gapped_shift();
        test_sync_with_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
